dram_axil_responder: RTL and testbench

- Synthesizable AXI4-Lite responder (slave) modelling the DRAM side of the bridge link, i.e. the other end of the bridge's AR/R/AW/W/B channels.
- Holds the user-record store as 64-bit words at byte addresses BASE_ADDR + 8*k.
- Services one outstanding read and one outstanding write at a time, with programmable latency.
- Used as a gate-level-capable replacement for the behavioural DRAM model and as a bridge regression target.

---
 rtl/dram_axil_responder.sv | 252 +++++++++++++++++++++++++
 tb/tb_dram_axil_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_axil_responder.sv
// rtl/dram_axil_responder.sv - AXI4-Lite responder holding a 64-bit word store with programmable latency
// Optional: define DRAM_RAND_LAT_EN to add 0..7 LFSR-chosen extra cycles per transaction.
module dram_axil_responder #(
  parameter logic [16:0] BASE_ADDR = 17'h10000,
  parameter int          DEPTH     = 256,
  parameter int          RD_LAT    = 4,
  parameter int          WR_LAT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  output logic [1:0]  R_RESP,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  output logic [1:0]  B_RESP,
  input  logic        B_READY
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_COLLECT, WR_WAIT, WR_RESP} wr_state_t;

  function automatic logic addr_ok(input logic [16:0] a);
    return (a[2:0] == 3'd0) && (a >= BASE_ADDR) &&
           ((32'(a - BASE_ADDR) >> 3) < 32'(DEPTH));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [16:0] a);
    return IW'((a - BASE_ADDR) >> 3);
  endfunction

  logic [63:0] mem [DEPTH];

  rd_state_t   rd_state_q, rd_state_d;
  logic [4:0]  rd_cnt_q, rd_cnt_d;
  logic        rd_ok_q, rd_ok_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic        ar_ready_q, ar_ready_d;
  logic        r_valid_q, r_valid_d;
  logic [63:0] r_data_q, r_data_d;
  logic [1:0]  r_resp_q, r_resp_d;

  wr_state_t   wr_state_q, wr_state_d;
  logic [4:0]  wr_cnt_q, wr_cnt_d;
  logic        aw_ok_q, aw_ok_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic        aw_ready_q, aw_ready_d;
  logic        w_ready_q, w_ready_d;
  logic        b_valid_q, b_valid_d;
  logic [1:0]  b_resp_q, b_resp_d;
  logic        mem_we;

  logic [2:0]  lat_extra;
  logic [4:0]  rd_load, wr_load;
  logic        aw_hs, w_hs;

`ifdef DRAM_RAND_LAT_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign lat_extra = lfsr_q[2:0];
`else
  assign lat_extra = 3'd0;
`endif

  // Counter holds cycles remaining minus one, so the response lands LAT edges after the latch.
  assign rd_load = 5'(RD_LAT - 1) + {2'b00, lat_extra};
  assign wr_load = 5'(WR_LAT - 1) + {2'b00, lat_extra};
  assign aw_hs   = AW_VALID && aw_ready_q;
  assign w_hs    = W_VALID && w_ready_q;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_ok_d    = rd_ok_q;
    rd_idx_d   = rd_idx_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (AR_VALID && ar_ready_q) begin
          rd_ok_d    = addr_ok(AR_ADDR);
          rd_idx_d   = word_idx(AR_ADDR);
          ar_ready_d = 1'b0;
          rd_cnt_d   = rd_load;
          rd_state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_cnt_q == 5'd0) begin
          // Array read sees the pre-commit value when a write lands on this same edge.
          r_data_d   = rd_ok_q ? mem[rd_idx_q] : 64'd0;
          r_resp_d   = rd_ok_q ? RESP_OKAY : RESP_SLVERR;
          r_valid_d  = 1'b1;
          rd_state_d = RD_RESP;
        end else begin
          rd_cnt_d = rd_cnt_q - 5'd1;
        end
      end
      RD_RESP: begin
        if (R_READY) begin
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
        ar_ready_d = 1'b1;
        r_valid_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    aw_ok_d    = aw_ok_q;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    mem_we     = 1'b0;
    case (wr_state_q)
      WR_COLLECT: begin
        if (aw_hs) begin
          aw_ok_d    = addr_ok(AW_ADDR);
          wr_idx_d   = word_idx(AW_ADDR);
          aw_ready_d = 1'b0;
        end
        if (w_hs) begin
          wr_data_d = W_DATA;
          w_ready_d = 1'b0;
        end
        // A dropped ready marks that channel as already held.
        if ((aw_hs || !aw_ready_q) && (w_hs || !w_ready_q)) begin
          wr_cnt_d   = wr_load;
          wr_state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (wr_cnt_q == 5'd0) begin
          mem_we     = aw_ok_q;
          b_resp_d   = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
          b_valid_d  = 1'b1;
          wr_state_d = WR_RESP;
        end else begin
          wr_cnt_d = wr_cnt_q - 5'd1;
        end
      end
      WR_RESP: begin
        if (B_READY) begin
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
          w_ready_d  = 1'b1;
          wr_state_d = WR_COLLECT;
        end
      end
      default: begin
        wr_state_d = WR_COLLECT;
        aw_ready_d = 1'b1;
        w_ready_d  = 1'b1;
        b_valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      rd_cnt_q   <= '0;
      rd_ok_q    <= 1'b0;
      rd_idx_q   <= '0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_ok_q    <= rd_ok_d;
      rd_idx_q   <= rd_idx_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_COLLECT;
      wr_cnt_q   <= '0;
      aw_ok_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
      b_resp_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      aw_ok_q    <= aw_ok_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
    end
  end

  // Store is deliberately outside reset; a reset edge never commits.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[wr_idx_q] <= wr_data_q;
  end

  assign AR_READY = ar_ready_q;
  assign R_VALID  = r_valid_q;
  assign R_DATA   = r_data_q;
  assign R_RESP   = r_resp_q;
  assign AW_READY = aw_ready_q;
  assign W_READY  = w_ready_q;
  assign B_VALID  = b_valid_q;
  assign B_RESP   = b_resp_q;

endmodule

// File: tb/tb_dram_axil_responder.sv
// tb/tb_dram_axil_responder.sv - randomized self-checking bench for dram_axil_responder
module tb_dram_axil_responder;

  localparam int BASE  = 65536;
  localparam int DEPTH = 256;
  localparam int RDL   = 4;
  localparam int WRL   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        AR_VALID, AR_READY, R_VALID, R_READY;
  logic [16:0] AR_ADDR, AW_ADDR;
  logic [63:0] R_DATA, W_DATA;
  logic [1:0]  R_RESP, B_RESP;
  logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;

  int n_chk = 0;
  int n_pass = 0;
  int edge_n = 0;

  logic [63:0] model [DEPTH];
  bit          known [DEPTH];

  dram_axil_responder dut (
    .clk(clk), .rst(rst),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic bit exp_ok(input logic [16:0] a);
    int ai;
    ai = int'(a);
    return (ai % 8 == 0) && (ai >= BASE) && ((ai - BASE) / 8 < DEPTH);
  endfunction

  function automatic int exp_idx(input logic [16:0] a);
    return (int'(a) - BASE) / 8;
  endfunction

  function automatic void model_write(input logic [16:0] a, input logic [63:0] d);
    if (exp_ok(a)) begin
      model[exp_idx(a)] = d;
      known[exp_idx(a)] = 1'b1;
    end
  endfunction

  task automatic axi_read(input logic [16:0] a, input int dly, input int hold, input bit early,
                          output logic [63:0] data, output logic [1:0] resp, output int lat,
                          output bit stable, output bit rdy_back, output bit ok);
    int cyc;
    int hs_edge;
    bit hs;
    ok = 1; stable = 1; rdy_back = 0; lat = -1; data = 'x; resp = 'x; hs = 0; cyc = 0;
    R_READY = early;
    while (!hs && cyc < 100) begin
      AR_VALID = (cyc >= dly);
      AR_ADDR  = AR_VALID ? a : 17'($urandom);
      hs = AR_VALID && AR_READY;
      @(negedge clk);
      cyc++;
    end
    AR_VALID = 1'b0;
    AR_ADDR  = 17'($urandom);
    if (!hs) begin ok = 0; R_READY = 1'b0; return; end
    hs_edge = edge_n;
    cyc = 0;
    while (!R_VALID && cyc < 100) begin @(negedge clk); cyc++; end
    if (!R_VALID) begin ok = 0; R_READY = 1'b0; return; end
    lat = edge_n - hs_edge; data = R_DATA; resp = R_RESP;
    if (!early) begin
      repeat (hold) begin
        @(negedge clk);
        if (!R_VALID || R_DATA !== data || R_RESP !== resp || AR_READY) stable = 0;
      end
      R_READY = 1'b1;
    end
    @(negedge clk);
    R_READY = 1'b0;
    rdy_back = AR_READY && !R_VALID;
  endtask

  task automatic axi_write(input logic [16:0] a, input logic [63:0] d, input int aw_dly, input int w_dly,
                           input int hold, input bit early, output logic [1:0] resp, output int lat,
                           output bit low_ok, output bit stable, output bit rdy_back, output bit ok);
    int cyc;
    int done_edge;
    bit aw_done, w_done, aw_hs, w_hs;
    ok = 1; low_ok = 1; stable = 1; rdy_back = 0; lat = -1; resp = 'x;
    aw_done = 0; w_done = 0; cyc = 0;
    B_READY = early;
    while (!(aw_done && w_done) && cyc < 100) begin
      AW_VALID = !aw_done && (cyc >= aw_dly);
      W_VALID  = !w_done && (cyc >= w_dly);
      AW_ADDR  = AW_VALID ? a : 17'($urandom);
      W_DATA   = W_VALID ? d : {$urandom, $urandom};
      aw_hs = AW_VALID && AW_READY;
      w_hs  = W_VALID && W_READY;
      if (aw_done && AW_READY) low_ok = 0;
      if (w_done && W_READY) low_ok = 0;
      @(negedge clk);
      cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
    end
    AW_VALID = 1'b0; W_VALID = 1'b0;
    AW_ADDR = 17'($urandom); W_DATA = {$urandom, $urandom};
    if (!(aw_done && w_done)) begin ok = 0; B_READY = 1'b0; return; end
    if (AW_READY || W_READY) low_ok = 0;
    done_edge = edge_n;
    cyc = 0;
    while (!B_VALID && cyc < 100) begin @(negedge clk); cyc++; end
    if (!B_VALID) begin ok = 0; B_READY = 1'b0; return; end
    lat = edge_n - done_edge; resp = B_RESP;
    if (!early) begin
      repeat (hold) begin
        @(negedge clk);
        if (!B_VALID || B_RESP !== resp || AW_READY || W_READY) stable = 0;
      end
      B_READY = 1'b1;
    end
    @(negedge clk);
    B_READY = 1'b0;
    rdy_back = AW_READY && W_READY && !B_VALID;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if ({AR_READY, AW_READY, W_READY} !== 3'b111) $display("FAIL reset_readies actual=%b required=111", {AR_READY, AW_READY, W_READY}); else n_pass++;
    n_chk++; if ({R_VALID, B_VALID} !== 2'b00) $display("FAIL reset_valids actual=%b required=00", {R_VALID, B_VALID}); else n_pass++;
    n_chk++; if (R_DATA !== 64'd0) $display("FAIL reset_rdata actual=%h required=0", R_DATA); else n_pass++;
    n_chk++; if ({R_RESP, B_RESP} !== 4'b0000) $display("FAIL reset_resp actual=%b required=0000", {R_RESP, B_RESP}); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [63:0] d; logic [1:0] rs; int lat; bit lo, st, rb, ok;
    axi_write(17'h10008, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 1, rs, lat, lo, st, rb, ok);
    model_write(17'h10008, 64'h0123_4567_89AB_CDEF);
    n_chk++; if (!ok || lat != WRL) $display("FAIL wr_latency actual=%0d required=%0d", lat, WRL); else n_pass++;
    n_chk++; if (rs !== 2'b00) $display("FAIL wr_resp actual=%b required=00", rs); else n_pass++;
    n_chk++; if (!rb) $display("FAIL wr_ready_back actual=0 required=1"); else n_pass++;
    axi_read(17'h10008, 0, 0, 1, d, rs, lat, st, rb, ok);
    n_chk++; if (!ok || lat != RDL) $display("FAIL rd_latency actual=%0d required=%0d", lat, RDL); else n_pass++;
    n_chk++; if (d !== 64'h0123_4567_89AB_CDEF || rs !== 2'b00) $display("FAIL rd_data actual=%h/%b required=0123456789abcdef/00", d, rs); else n_pass++;
  endtask

  task automatic test_split_write();
    logic [63:0] d; logic [1:0] rs; int lat; bit lo, st, rb, ok;
    axi_write(17'h10010, 64'h55, 3, 0, 0, 1, rs, lat, lo, st, rb, ok);
    model_write(17'h10010, 64'h55);
    n_chk++; if (!lo) $display("FAIL split_ready_low actual=1 required=0"); else n_pass++;
    n_chk++; if (!ok || lat != WRL || rs !== 2'b00) $display("FAIL split_wr actual=%0d/%b required=%0d/00", lat, rs, WRL); else n_pass++;
    axi_read(17'h10010, 0, 0, 1, d, rs, lat, st, rb, ok);
    n_chk++; if (!ok || d !== 64'h55) $display("FAIL split_readback actual=%h required=55", d); else n_pass++;
  endtask

  task automatic test_errors();
    logic [63:0] d; logic [1:0] rs; int lat; bit lo, st, rb, ok;
    axi_write(17'h10000, 64'hFEED_F00D_0000_1111, 0, 1, 2, 0, rs, lat, lo, st, rb, ok);
    model_write(17'h10000, 64'hFEED_F00D_0000_1111);
    axi_read(17'h10004, 0, 0, 1, d, rs, lat, st, rb, ok);
    n_chk++; if (!ok || rs !== 2'b10 || d !== 64'd0) $display("FAIL rd_misaligned actual=%h/%b required=0/10", d, rs); else n_pass++;
    axi_write(17'h0FFF8, 64'hDEAD, 0, 0, 0, 1, rs, lat, lo, st, rb, ok);
    n_chk++; if (!ok || rs !== 2'b10) $display("FAIL wr_below_base actual=%b required=10", rs); else n_pass++;
    axi_read(17'h10000, 0, 0, 1, d, rs, lat, st, rb, ok);
    n_chk++; if (!ok || d !== model[0]) $display("FAIL base_unchanged actual=%h required=%h", d, model[0]); else n_pass++;
    axi_write(17'h107F8, 64'h7F8, 0, 0, 0, 1, rs, lat, lo, st, rb, ok);
    model_write(17'h107F8, 64'h7F8);
    axi_read(17'h107F8, 0, 0, 1, d, rs, lat, st, rb, ok);
    n_chk++; if (!ok || rs !== 2'b00 || d !== 64'h7F8) $display("FAIL last_word actual=%h/%b required=7f8/00", d, rs); else n_pass++;
    axi_read(17'h10800, 0, 0, 1, d, rs, lat, st, rb, ok);
    n_chk++; if (!ok || rs !== 2'b10 || d !== 64'd0) $display("FAIL past_depth actual=%h/%b required=0/10", d, rs); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] d; logic [1:0] rs; int lat; bit st, rb, ok;
    axi_read(17'h10008, 0, 10, 0, d, rs, lat, st, rb, ok);
    n_chk++; if (!ok || !st) $display("FAIL rd_hold_stable actual=%0d required=1", st); else n_pass++;
    n_chk++; if (d !== model[1]) $display("FAIL rd_hold_data actual=%h required=%h", d, model[1]); else n_pass++;
    n_chk++; if (!rb) $display("FAIL rd_retire_ready actual=0 required=1"); else n_pass++;
  endtask

  task automatic test_collision();
    logic [63:0] d, d2; logic [1:0] rs, rs2; int lat, lat2; bit lo, st, st2, rb, rb2, ok, ok2;
    axi_write(17'h10020, 64'hAA, 0, 0, 0, 1, rs, lat, lo, st, rb, ok);
    model_write(17'h10020, 64'hAA);
    fork
      axi_read(17'h10020, 0, 0, 1, d, rs, lat, st, rb, ok);
      axi_write(17'h10020, 64'hBB, 0, 0, 0, 1, rs2, lat2, lo, st2, rb2, ok2);
    join
    n_chk++; if (!ok || !ok2 || d !== 64'hAA) $display("FAIL collision_old actual=%h required=aa", d); else n_pass++;
    model_write(17'h10020, 64'hBB);
    axi_read(17'h10020, 0, 0, 1, d, rs, lat, st, rb, ok);
    n_chk++; if (!ok || d !== 64'hBB) $display("FAIL collision_new actual=%h required=bb", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int hs_edges[$];
    int cyc;
    bit hs;
    AR_ADDR = 17'h10008; AR_VALID = 1'b1; R_READY = 1'b1;
    cyc = 0;
    while (hs_edges.size() < 3 && cyc < 60) begin
      hs = AR_READY;
      @(negedge clk);
      cyc++;
      if (hs) hs_edges.push_back(edge_n);
    end
    AR_VALID = 1'b0;
    cyc = 0;
    while (!(AR_READY && !R_VALID) && cyc < 30) begin @(negedge clk); cyc++; end
    R_READY = 1'b0;
    n_chk++; if (hs_edges.size() != 3) $display("FAIL b2b_count actual=%0d required=3", hs_edges.size()); else n_pass++;
    for (int i = 1; i < hs_edges.size(); i++) begin
      n_chk++; if (hs_edges[i] - hs_edges[i-1] != RDL + 2) $display("FAIL b2b_spacing actual=%0d required=%0d", hs_edges[i] - hs_edges[i-1], RDL + 2); else n_pass++;
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] d; logic [1:0] rs; int lat; bit st, rb, ok, seen;
    AW_ADDR = 17'h10000; W_DATA = 64'h1234; AW_VALID = 1'b1; W_VALID = 1'b1;
    @(negedge clk);
    AW_VALID = 1'b0; W_VALID = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if ({AR_READY, AW_READY, W_READY} !== 3'b111) $display("FAIL midop_readies actual=%b required=111", {AR_READY, AW_READY, W_READY}); else n_pass++;
    seen = 0;
    repeat (10) begin @(negedge clk); if (B_VALID) seen = 1; end
    n_chk++; if (seen) $display("FAIL midop_no_bvalid actual=1 required=0"); else n_pass++;
    axi_read(17'h10000, 0, 0, 1, d, rs, lat, st, rb, ok);
    n_chk++; if (!ok || d !== model[0]) $display("FAIL midop_mem actual=%h required=%h", d, model[0]); else n_pass++;
  endtask

  task automatic test_random();
    logic [16:0] a; logic [63:0] wd, d; logic [1:0] rs, er; int lat, kind; bit lo, st, rb, ok;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0: a = 17'(BASE + 8 * $urandom_range(0, 15) + $urandom_range(1, 7));
        1: a = 17'(8 * $urandom_range(0, 8191));
        2: a = 17'(BASE + 8 * $urandom_range(DEPTH, 8191));
        default: a = 17'(BASE + 8 * $urandom_range(0, 15));
      endcase
      er = exp_ok(a) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 1) begin
        wd = {$urandom, $urandom};
        axi_write(a, wd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  rs, lat, lo, st, rb, ok);
        model_write(a, wd);
        n_chk++; if (!ok || rs !== er || lat != WRL) $display("FAIL rand_wr a=%h actual=%b/%0d required=%b/%0d", a, rs, lat, er, WRL); else n_pass++;
        n_chk++; if (!lo || !st || !rb) $display("FAIL rand_wr_hs a=%h actual=%0d%0d%0d required=111", a, lo, st, rb); else n_pass++;
      end else begin
        axi_read(a, $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)), d, rs, lat, st, rb, ok);
        n_chk++; if (!ok || rs !== er || lat != RDL) $display("FAIL rand_rd a=%h actual=%b/%0d required=%b/%0d", a, rs, lat, er, RDL); else n_pass++;
        n_chk++; if (!st || !rb) $display("FAIL rand_rd_hs a=%h actual=%0d%0d required=11", a, st, rb); else n_pass++;
        if (!exp_ok(a)) begin
          n_chk++; if (d !== 64'd0) $display("FAIL rand_rd_err_data a=%h actual=%h required=0", a, d); else n_pass++;
        end else if (known[exp_idx(a)]) begin
          n_chk++; if (d !== model[exp_idx(a)]) $display("FAIL rand_rd_data a=%h actual=%h required=%h", a, d, model[exp_idx(a)]); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    AR_VALID = 1'b0; AR_ADDR = '0; R_READY = 1'b0;
    AW_VALID = 1'b0; AW_ADDR = '0; W_VALID = 1'b0; W_DATA = '0; B_READY = 1'b0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_split_write();
    test_errors();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
